// File: rtl/ne_layer_sched_ctrl_param.sv
// ---------------------------------------------------------------------------
// ne_layer_sched_ctrl_param
//
// Purpose:
//   Schedule controller for a P-lane layered decoder row computer. It steps
//   through ROWDEPTH rows of every layer, one row per cycle, and waits
//   PIPESTAGES drain cycles after each layer. After the last layer of an
//   iteration it spends one check cycle deciding between another iteration
//   and completion. Completion happens on the latched iteration limit or on
//   a parity pass when early termination is enabled. The last row of each
//   layer carries only P_LAST valid lanes, so the per-lane enables are
//   masked on that row.
//
// Ports:
//   clk              clock
//   rst              asynchronous reset, active low
//   loaden           input interface is writing the frame into Lmem
//   start            begin decoding the loaded frame
//   abort            synchronous return to IDLE with all outputs cleared
//   max_itr          runtime iteration limit (0 or >MAXITRS means MAXITRS)
//   et_en            early-termination enable, latched when start is taken
//   parity_ok        syndrome pass flag, looked at only in the check cycle
//   decoder_ready    decode finished, result available
//   busy             row reading, draining or iteration check in progress
//   first_processing Lmem returns the freshly loaded data (layer 0, iter 0)
//   layer_idx        current layer
//   row_addr         current row address
//   rd_L             Lmem read enable
//   rcu_en           per-lane RCU enable
//   rden_E           per-lane Dmem re-access enable (zero in iteration 0)
//   itr_count        iterations completed
//   et_flag          last decode ended by early termination
//   dbg_state        FSM state, for observation only
//
// Handshake: start and loaden are level inputs sampled on the rising edge;
// start is taken only in IDLE, LOAD or DONE while loaden is low, and loaden
// wins when both are high. abort outranks every other input; rst outranks
// abort. decoder_ready stays high in DONE until the next frame is accepted.
// ---------------------------------------------------------------------------
module ne_layer_sched_ctrl_param #(
  parameter int Z              = 511,
  parameter int P              = 26,
  parameter int LAYERS         = 2,
  parameter int ROWDEPTH       = 20,
  parameter int ROWWIDTH       = 5,
  parameter int LAYERWIDTH     = 1,
  parameter int PIPESTAGES     = 13,
  parameter int PIPECOUNTWIDTH = 4,
  parameter int MAXITRS        = 10,
  parameter int ITRWIDTH       = 4,
  parameter int P_LAST         = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  loaden,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITRWIDTH-1:0]   max_itr,
  input  logic                  et_en,
  input  logic                  parity_ok,
  output logic                  decoder_ready,
  output logic                  busy,
  output logic                  first_processing,
  output logic [LAYERWIDTH-1:0] layer_idx,
  output logic [ROWWIDTH-1:0]   row_addr,
  output logic                  rd_L,
  output logic [P-1:0]          rcu_en,
  output logic [P-1:0]          rden_E,
  output logic [ITRWIDTH-1:0]   itr_count,
  output logic                  et_flag,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_READ   = 3'd2,
    S_DRAIN  = 3'd3,
    S_ITRCHK = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // An out-of-range P_LAST falls back to the lane count implied by Z.
  localparam int LAST_LANES = (P_LAST >= 1 && P_LAST <= P) ? P_LAST
                                                           : (Z - P * (ROWDEPTH - 1));
  // Lanes [LAST_LANES-1:0] set; all ones when LAST_LANES == P.
  localparam logic [P-1:0]              LAST_MASK  = {P{1'b1}} >> (P - LAST_LANES);
  localparam logic [P-1:0]              FULL_MASK  = {P{1'b1}};
  localparam logic [ROWWIDTH-1:0]       LAST_ROW   = ROWWIDTH'(ROWDEPTH - 1);
  localparam logic [LAYERWIDTH-1:0]     LAST_LAYER = LAYERWIDTH'(LAYERS - 1);
  localparam logic [PIPECOUNTWIDTH-1:0] LAST_PIPE  = PIPECOUNTWIDTH'(PIPESTAGES - 1);
  localparam logic [ITRWIDTH-1:0]       MAX_LIMIT  = ITRWIDTH'(MAXITRS);

  state_e                    state_q, state_d;
  logic [ROWWIDTH-1:0]       row_q, row_d;
  logic [LAYERWIDTH-1:0]     layer_q, layer_d;
  logic [PIPECOUNTWIDTH-1:0] pcnt_q, pcnt_d;
  logic [ITRWIDTH-1:0]       itr_q, itr_d;
  logic [ITRWIDTH-1:0]       limit_q, limit_d;
  logic                      eten_q, eten_d;
  logic                      etf_q, etf_d;
  logic                      first_q, first_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      rd_q, rd_d;
  logic [P-1:0]              rcu_q, rcu_d;
  logic [P-1:0]              rden_q, rden_d;

  logic                      accept;
  logic [ITRWIDTH-1:0]       itr_inc;

  assign itr_inc = itr_q + 1'b1;

  function automatic logic [P-1:0] row_mask(input logic [ROWWIDTH-1:0] r);
    return (r == LAST_ROW) ? LAST_MASK : FULL_MASK;
  endfunction

  // -------------------------------------------------------------------------
  // Next-state and registered-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    layer_d = layer_q;
    pcnt_d  = pcnt_q;
    itr_d   = itr_q;
    limit_d = limit_q;
    eten_d  = eten_q;
    etf_d   = etf_q;
    first_d = first_q;
    ready_d = ready_q;
    busy_d  = 1'b0;
    rd_d    = 1'b0;
    rcu_d   = '0;
    rden_d  = '0;
    accept  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (loaden) begin
          state_d = S_LOAD;
          first_d = 1'b1;
        end else if (start) begin
          accept = 1'b1;
        end
      end

      S_LOAD: begin
        first_d = 1'b1;
        if (!loaden && start) begin
          accept = 1'b1;
        end
      end

      S_READ: begin
        if (row_q == LAST_ROW) begin
          state_d = S_DRAIN;
          pcnt_d  = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end

      S_DRAIN: begin
        if (pcnt_q == LAST_PIPE) begin
          // From here on Lmem holds updated values, not the loaded frame.
          if (layer_q == '0 && itr_q == '0) begin
            first_d = 1'b0;
          end
          if (layer_q != LAST_LAYER) begin
            layer_d = layer_q + 1'b1;
            row_d   = '0;
            state_d = S_READ;
          end else begin
            state_d = S_ITRCHK;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end

      S_ITRCHK: begin
        itr_d = itr_inc;
        if (eten_q && parity_ok) begin
          etf_d   = 1'b1;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else if (itr_inc == limit_q) begin
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          layer_d = '0;
          row_d   = '0;
          state_d = S_READ;
        end
      end

      S_DONE: begin
        if (loaden) begin
          ready_d = 1'b0;
          first_d = 1'b1;
          state_d = S_LOAD;
        end else if (start) begin
          accept = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frame acceptance: latch run configuration and restart at row 0, layer 0.
    if (accept) begin
      if (max_itr == '0 || int'(max_itr) > MAXITRS) begin
        limit_d = MAX_LIMIT;
      end else begin
        limit_d = max_itr;
      end
      eten_d  = et_en;
      first_d = 1'b1;
      itr_d   = '0;
      etf_d   = 1'b0;
      ready_d = 1'b0;
      row_d   = '0;
      layer_d = '0;
      state_d = S_READ;
    end

    if (abort) begin
      state_d = S_IDLE;
      row_d   = '0;
      layer_d = '0;
      pcnt_d  = '0;
      itr_d   = '0;
      limit_d = '0;
      eten_d  = 1'b0;
      etf_d   = 1'b0;
      first_d = 1'b0;
      ready_d = 1'b0;
    end

    // Row-cycle enables describe the row that is read in the next cycle.
    // Dmem re-access only makes sense once an iteration has written it.
    if (state_d == S_READ) begin
      rd_d   = 1'b1;
      rcu_d  = row_mask(row_d);
      rden_d = (itr_d != '0) ? row_mask(row_d) : '0;
    end

    busy_d = (state_d == S_READ) || (state_d == S_DRAIN) || (state_d == S_ITRCHK);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      layer_q <= '0;
      pcnt_q  <= '0;
      itr_q   <= '0;
      limit_q <= '0;
      eten_q  <= 1'b0;
      etf_q   <= 1'b0;
      first_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      rcu_q   <= '0;
      rden_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      layer_q <= layer_d;
      pcnt_q  <= pcnt_d;
      itr_q   <= itr_d;
      limit_q <= limit_d;
      eten_q  <= eten_d;
      etf_q   <= etf_d;
      first_q <= first_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      rcu_q   <= rcu_d;
      rden_q  <= rden_d;
    end
  end

  assign decoder_ready    = ready_q;
  assign busy             = busy_q;
  assign first_processing = first_q;
  assign layer_idx        = layer_q;
  assign row_addr         = row_q;
  assign rd_L             = rd_q;
  assign rcu_en           = rcu_q;
  assign rden_E           = rden_q;
  assign itr_count        = itr_q;
  assign et_flag          = etf_q;
  assign dbg_state        = state_q;

endmodule

// File: doc/ne_layer_sched_ctrl_param.md
Name: ne_layer_sched_ctrl_param

Overview:
- Parametrised next-generation schedule controller for the P-lane layered SRQ decoder row computer.
- Generalises the fixed-P/fixed-layer address-generation FSM to any Z, P and LAYERS, with a masked partial last row (P_LAST lanes), a runtime iteration limit, early termination on a parity pass, and a synchronous abort.
- Drives Lmem/Dmem read addressing and the per-lane RCU enables; sits between the input/output interfaces and the RCU array.

Parameters:
- Z, 511: circulant size.
- P, 26: parallel RCU lanes.
- LAYERS, 2: layers per iteration.
- ROWDEPTH, 20: rows per layer = ceil(Z/P).
- ROWWIDTH, 5: row address width; 2**ROWWIDTH >= ROWDEPTH.
- LAYERWIDTH, 1: layer index width; 2**LAYERWIDTH >= LAYERS.
- PIPESTAGES, 13: drain cycles after the last row of a layer (memory read + RCU pipeline).
- PIPECOUNTWIDTH, 4: drain counter width.
- MAXITRS, 10: hard iteration cap.
- ITRWIDTH, 4: iteration counter width.
- P_LAST, 17: valid lanes in row ROWDEPTH-1 = Z-P*(ROWDEPTH-1).

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous reset, active-low.
- loaden, input, 1: input interface is loading the frame into Lmem.
- start, input, 1: begin decoding the loaded frame.
- abort, input, 1: synchronous abort to IDLE.
- max_itr, input, ITRWIDTH: runtime iteration limit, latched on start acceptance.
- et_en, input, 1: early-termination enable, latched on start acceptance.
- parity_ok, input, 1: syndrome-checker pass flag, sampled only in ITRCHK.
- decoder_ready, output, 1: decode complete, result available.
- busy, output, 1: high in READ, DRAIN and ITRCHK.
- first_processing, output, 1: Lmem selects loaded data for layer 0.
- layer_idx, output, LAYERWIDTH: current layer.
- row_addr, output, ROWWIDTH: current row address.
- rd_L, output, 1: Lmem read enable.
- rcu_en, output, P: per-lane RCU enable.
- rden_E, output, P: per-lane Dmem reaccess enable.
- itr_count, output, ITRWIDTH: iterations completed.
- et_flag, output, 1: last decode ended by early termination.

Behaviour:
- All outputs are registered. Async reset (rst=0) forces state IDLE and drives every output to 0.
- Reset mid-operation discards the frame; the next frame needs loaden/start again.
- State IDLE:
  - loaden=1 -> LOAD.
  - start=1 with loaden=0 -> READ. In the same edge: latch limit, set first_processing=1, clear itr_count and et_flag.
- State LOAD:
  - first_processing=1.
  - Stays while loaden=1. Start is ignored while loaden=1.
  - start with loaden=0 -> READ with the same latch actions as IDLE.
- Limit rule: latched limit = MAXITRS if max_itr==0 or max_itr>MAXITRS; otherwise limit = max_itr.
- State READ:
  - One row per cycle, row_addr 0..ROWDEPTH-1, at layer_idx; rd_L=1.
  - rcu_en is all ones, except row ROWDEPTH-1, where only lanes [P_LAST-1:0] are 1.
  - rden_E uses the same mask during iterations >=1 and is all zeros during iteration 0.
  - After row ROWDEPTH-1 -> DRAIN, with rd_L, rcu_en and rden_E cleared.
- State DRAIN:
  - Counts PIPESTAGES cycles.
  - At the end of the drain for layer 0 of iteration 0, first_processing clears.
  - If layer_idx<LAYERS-1: layer_idx+1, row_addr=0, -> READ.
  - Otherwise -> ITRCHK.
- State ITRCHK (1 cycle):
  - itr_count+1.
  - If (et_en && parity_ok): et_flag=1, -> DONE.
  - Else if itr_count+1==limit: -> DONE.
  - Else: layer_idx=0, row_addr=0, -> READ.
- State DONE:
  - decoder_ready=1; itr_count and et_flag held.
  - start (with loaden=0) -> READ, clearing decoder_ready.
  - loaden -> LOAD, clearing decoder_ready.
  - Simultaneous start and loaden: loaden wins.
- abort=1 in any state -> IDLE next edge with all outputs cleared; abort outranks all other inputs. rst outranks abort.
- Cycle count:
  - Per iteration = LAYERS*(ROWDEPTH+PIPESTAGES)+1.
  - decoder_ready rises iters*(that) edges after the start-accept edge. Default parameters give 67 per iteration.
- Wrap-around: row_addr and layer_idx return to 0 and never exceed ROWDEPTH-1 or LAYERS-1. itr_count never exceeds the limit.
- Degenerate configuration: if P_LAST==P, the last row is unmasked.

Test Plan:
- Defaults, max_itr=2, et_en=0, start pulse -> 20 READ cycles per layer, row_addr 0..19, 13 DRAIN cycles; decoder_ready rises 134 edges after start; itr_count=2, et_flag=0.
- Row 19 of any layer -> rcu_en=26'h001FFFF. Iteration 0 -> rden_E=0. Iteration 1 -> rden_E=rcu_en.
- max_itr=0 and max_itr=15 -> both run 10 iterations; ready at edge 670; itr_count=10.
- et_en=1, parity_ok=1 from iteration 3 onward, max_itr=10 -> DONE after ITRCHK of iteration 3; itr_count=3, et_flag=1, ready at edge 201.
- loaden held 5 cycles with start asserted during it -> stays in LOAD with first_processing=1; start after loaden falls is accepted; first_processing clears at the end of the layer-0 drain.
- abort at edge 50, or rst low mid-READ -> all outputs 0 within 1 edge (async for rst); the next start decodes normally from row 0, layer 0.
